// File: rtl/rvh_ptw_walk_arb_pkg.sv
// Shared MMU definitions used by the page-table-walk arbiter and its ID FIFO.
package rvh_ptw_walk_arb_pkg;

    localparam int MMU_WALKER_NUM  = 32'sd2;
    localparam int MMU_PADDR_WIDTH = 32'sd56;
    localparam int MMU_PTE_WIDTH   = 32'sd64;
    localparam int MMU_OUTSTANDING = 32'sd4;

    function automatic int ptw_id_width_f(input int walker_num);
        return (walker_num > 32'sd1) ? $clog2(walker_num) : 32'sd1;
    endfunction

    localparam int MMU_PTW_ID_WIDTH = ptw_id_width_f(MMU_WALKER_NUM);

    typedef struct packed {
        logic [MMU_PTW_ID_WIDTH-1:0] id;
        logic [MMU_PADDR_WIDTH-1:0]  addr;
    } ptw_walk_req_t;

endpackage

// File: rtl/rvh_ptw_walk_arb_if.sv
// Memory-side page-table-walk request/response bus between the arbiter and L1D/bus.
interface rvh_ptw_walk_arb_if
    import rvh_ptw_walk_arb_pkg::*;
#(
    parameter int PADDR_WIDTH  = MMU_PADDR_WIDTH,
    parameter int PTE_WIDTH    = MMU_PTE_WIDTH,
    parameter int PTW_ID_WIDTH = MMU_PTW_ID_WIDTH
);

    logic                    ptw_walk_req_vld_o;
    logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_o;
    logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_o;
    logic                    ptw_walk_req_rdy_i;
    logic                    ptw_walk_resp_vld_i;
    logic [PTE_WIDTH-1:0]    ptw_walk_resp_pte_i;
    logic                    ptw_walk_resp_rdy_o;

    modport master (
        output ptw_walk_req_vld_o,
        output ptw_walk_req_id_o,
        output ptw_walk_req_addr_o,
        input  ptw_walk_req_rdy_i,
        input  ptw_walk_resp_vld_i,
        input  ptw_walk_resp_pte_i,
        output ptw_walk_resp_rdy_o
    );

    modport slave (
        input  ptw_walk_req_vld_o,
        input  ptw_walk_req_id_o,
        input  ptw_walk_req_addr_o,
        output ptw_walk_req_rdy_i,
        output ptw_walk_resp_vld_i,
        output ptw_walk_resp_pte_i,
        input  ptw_walk_resp_rdy_o
    );

endinterface

// File: rtl/rvh_ptw_id_fifo.sv
// In-order FIFO holding the walker index of every accepted walk request.
module rvh_ptw_id_fifo
    import rvh_ptw_walk_arb_pkg::*;
#(
    parameter int WIDTH = MMU_PTW_ID_WIDTH,
    parameter int DEPTH = MMU_OUTSTANDING,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 32'sd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_r == CW'(DEPTH));
    assign empty_o   = (count_r == {CW{1'b0}});
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign dout_o    = mem_r[rd_ptr_r];
    assign count_o   = count_r;

    // Storage, pointers (power-of-two depth wraps naturally) and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din_i;
                wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rvh_ptw_walk_arb.sv
// Round-robin arbiter sharing one PTW memory port between walkers; responses are
// routed back in order through the ID FIFO.
module rvh_ptw_walk_arb
    import rvh_ptw_walk_arb_pkg::*;
#(
    parameter int WALKER_NUM   = MMU_WALKER_NUM,
    parameter int PADDR_WIDTH  = MMU_PADDR_WIDTH,
    parameter int PTE_WIDTH    = MMU_PTE_WIDTH,
    parameter int OUTSTANDING  = MMU_OUTSTANDING,
    parameter int PTW_ID_WIDTH = ptw_id_width_f(WALKER_NUM),
    localparam int CNT_WIDTH   = $clog2(OUTSTANDING) + 32'sd1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WALKER_NUM-1:0]             walker_req_vld_i,
    input  logic [WALKER_NUM*PADDR_WIDTH-1:0] walker_req_addr_i,
    output logic [WALKER_NUM-1:0]             walker_req_rdy_o,
    output logic [WALKER_NUM-1:0]             walker_resp_vld_o,
    output logic [PTE_WIDTH-1:0]              walker_resp_pte_o,
    input  logic [WALKER_NUM-1:0]             walker_resp_rdy_i,
    rvh_ptw_walk_arb_if.master                ptw_walk,
    output logic [CNT_WIDTH-1:0]              outstanding_cnt_o,
    output logic                              protocol_err_o
);

    logic [PTW_ID_WIDTH-1:0] rr_ptr_r;
    logic [PTW_ID_WIDTH-1:0] lock_idx_r;
    logic                    lock_vld_r;
    logic                    err_r;
    logic [PTW_ID_WIDTH-1:0] cand_idx_s;
    logic [PTW_ID_WIDTH-1:0] rr_next_s;
    logic [PTW_ID_WIDTH-1:0] head_idx_s;
    logic [PADDR_WIDTH-1:0]  cand_addr_s;
    logic                    req_vld_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    orphan_resp_s;
    logic                    lock_lost_s;
    logic                    resp_rdy_s;

    // Candidate selection: first valid walker from rr_ptr upward, overridden by a held lock.
    always_comb begin
        logic                    found;
        logic [PTW_ID_WIDTH-1:0] scan;
        found      = 1'b0;
        scan       = rr_ptr_r;
        cand_idx_s = rr_ptr_r;
        for (int k = 0; k < WALKER_NUM; k++) begin
            scan = PTW_ID_WIDTH'((int'(rr_ptr_r) + k) % WALKER_NUM);
            if (!found && walker_req_vld_i[scan]) begin
                found      = 1'b1;
                cand_idx_s = scan;
            end else begin
                found = found;
            end
        end
        if (lock_vld_r) begin
            cand_idx_s = lock_idx_r;
        end else begin
            cand_idx_s = cand_idx_s;
        end
        rr_next_s   = PTW_ID_WIDTH'((int'(cand_idx_s) + 32'sd1) % WALKER_NUM);
        cand_addr_s = walker_req_addr_i[int'(cand_idx_s)*PADDR_WIDTH +: PADDR_WIDTH];
    end

    // Request path toward the memory port; held low while in reset so nothing leaks out.
    always_comb begin
        req_vld_s        = ((|walker_req_vld_i) | lock_vld_r) & ~full_s & ~rst;
        push_s           = req_vld_s & ptw_walk.ptw_walk_req_rdy_i;
        walker_req_rdy_o = {WALKER_NUM{1'b0}};
        if (!rst && !full_s && ptw_walk.ptw_walk_req_rdy_i) begin
            walker_req_rdy_o[cand_idx_s] = 1'b1;
        end else begin
            walker_req_rdy_o = {WALKER_NUM{1'b0}};
        end
    end

    assign ptw_walk.ptw_walk_req_vld_o  = req_vld_s;
    assign ptw_walk.ptw_walk_req_id_o   = cand_idx_s;
    assign ptw_walk.ptw_walk_req_addr_o = cand_addr_s;

    // Response routing to the walker at the FIFO head.
    always_comb begin
        walker_resp_vld_o = {WALKER_NUM{1'b0}};
        resp_rdy_s        = ~empty_s & walker_resp_rdy_i[head_idx_s];
        if (ptw_walk.ptw_walk_resp_vld_i && !empty_s) begin
            walker_resp_vld_o[head_idx_s] = 1'b1;
        end else begin
            walker_resp_vld_o = {WALKER_NUM{1'b0}};
        end
        pop_s         = ptw_walk.ptw_walk_resp_vld_i & resp_rdy_s;
        orphan_resp_s = ptw_walk.ptw_walk_resp_vld_i & empty_s;
        lock_lost_s   = lock_vld_r & ~walker_req_vld_i[lock_idx_r];
    end

    assign ptw_walk.ptw_walk_resp_rdy_o = resp_rdy_s;
    assign walker_resp_pte_o            = ptw_walk.ptw_walk_resp_pte_i;
    assign protocol_err_o               = err_r;

    // Round-robin pointer, grant lock and sticky protocol error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r   <= {PTW_ID_WIDTH{1'b0}};
            lock_idx_r <= {PTW_ID_WIDTH{1'b0}};
            lock_vld_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (push_s) begin
                rr_ptr_r   <= rr_next_s;
                lock_vld_r <= 1'b0;
            end else if (req_vld_s) begin
                lock_vld_r <= 1'b1;
                lock_idx_r <= cand_idx_s;
            end else begin
                lock_vld_r <= lock_vld_r;
            end
            if (orphan_resp_s || lock_lost_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    rvh_ptw_id_fifo #(
        .WIDTH (PTW_ID_WIDTH),
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .din_i   (cand_idx_s),
        .pop_i   (pop_s),
        .dout_o  (head_idx_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (outstanding_cnt_o)
    );

endmodule

// File: tb/tb_rvh_ptw_walk_arb.sv
// Directed bench for rvh_ptw_walk_arb: fairness, lock, ordering, backpressure, error, reset.
module tb_rvh_ptw_walk_arb;

    localparam int WN   = 2;
    localparam int PAW  = 56;
    localparam int PTEW = 64;
    localparam int OUT  = 4;
    localparam int IDW  = 1;
    localparam int CW   = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [WN-1:0]       walker_req_vld;
    logic [PAW-1:0]      addr0;
    logic [PAW-1:0]      addr1;
    logic [WN*PAW-1:0]   walker_req_addr;
    logic [WN-1:0]       walker_req_rdy;
    logic [WN-1:0]       walker_resp_vld;
    logic [PTEW-1:0]     walker_resp_pte;
    logic [WN-1:0]       walker_resp_rdy;
    logic [CW-1:0]       outstanding_cnt;
    logic                protocol_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign walker_req_addr = {addr1, addr0};

    rvh_ptw_walk_arb_if #(.PADDR_WIDTH(PAW), .PTE_WIDTH(PTEW), .PTW_ID_WIDTH(IDW)) bus ();

    rvh_ptw_walk_arb #(
        .WALKER_NUM  (WN),
        .PADDR_WIDTH (PAW),
        .PTE_WIDTH   (PTEW),
        .OUTSTANDING (OUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .walker_req_vld_i  (walker_req_vld),
        .walker_req_addr_i (walker_req_addr),
        .walker_req_rdy_o  (walker_req_rdy),
        .walker_resp_vld_o (walker_resp_vld),
        .walker_resp_pte_o (walker_resp_pte),
        .walker_resp_rdy_i (walker_resp_rdy),
        .ptw_walk          (bus),
        .outstanding_cnt_o (outstanding_cnt),
        .protocol_err_o    (protocol_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                     = 1'b1;
        walker_req_vld          = 2'b11;
        addr0                   = 56'h1000;
        addr1                   = 56'h2000;
        walker_resp_rdy         = 2'b11;
        bus.ptw_walk_req_rdy_i  = 1'b1;
        bus.ptw_walk_resp_vld_i = 1'b0;
        bus.ptw_walk_resp_pte_i = 64'h0;
        #2;
        chk("rst_req_vld", bus.ptw_walk_req_vld_o, 1'b0);
        chk("rst_req_rdy", walker_req_rdy, 2'b00);
        chk("rst_resp_vld", walker_resp_vld, 2'b00);
        chk("rst_resp_rdy", bus.ptw_walk_resp_rdy_o, 1'b0);
        chk("rst_cnt", outstanding_cnt, 3'd0);
        chk("rst_err", protocol_err, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Fairness: alternating grants until the FIFO fills
        for (int i = 0; i < 4; i++) begin
            chk("fair_vld", bus.ptw_walk_req_vld_o, 1'b1);
            chk("fair_id", bus.ptw_walk_req_id_o, (i % 2));
            chk("fair_addr", bus.ptw_walk_req_addr_o, (i % 2 == 1) ? 56'h2000 : 56'h1000);
            chk("fair_rdy", walker_req_rdy, (i % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            chk("fair_cnt", outstanding_cnt, i + 1);
        end
        chk("full_vld", bus.ptw_walk_req_vld_o, 1'b0);
        chk("full_rdy", walker_req_rdy, 2'b00);
        tick();
        chk("full_hold_cnt", outstanding_cnt, 3'd4);

        // First pop while full: request re-asserts the following cycle
        bus.ptw_walk_resp_vld_i = 1'b1;
        bus.ptw_walk_resp_pte_i = 64'h11;
        #1;
        chk("pop1_route", walker_resp_vld, 2'b01);
        chk("pop1_pte", walker_resp_pte, 64'h11);
        chk("pop1_rdy", bus.ptw_walk_resp_rdy_o, 1'b1);
        chk("pop1_req_blocked", bus.ptw_walk_req_vld_o, 1'b0);
        tick();
        chk("pop1_cnt", outstanding_cnt, 3'd3);
        bus.ptw_walk_resp_vld_i = 1'b0;
        #1;
        chk("reissue_vld", bus.ptw_walk_req_vld_o, 1'b1);
        chk("reissue_id", bus.ptw_walk_req_id_o, 1'b0);
        tick();
        chk("refill_cnt", outstanding_cnt, 3'd4);

        // Full with concurrent pop: count 4 -> 3 -> 4
        bus.ptw_walk_resp_vld_i = 1'b1;
        bus.ptw_walk_resp_pte_i = 64'h22;
        #1;
        chk("conc_route", walker_resp_vld, 2'b10);
        chk("conc_req_blocked", bus.ptw_walk_req_vld_o, 1'b0);
        tick();
        chk("conc_cnt3", outstanding_cnt, 3'd3);
        bus.ptw_walk_resp_vld_i = 1'b0;
        #1;
        chk("conc_reissue_vld", bus.ptw_walk_req_vld_o, 1'b1);
        chk("conc_reissue_id", bus.ptw_walk_req_id_o, 1'b1);
        tick();
        chk("conc_cnt4", outstanding_cnt, 3'd4);

        // Drain: FIFO holds 0,1,0,1
        walker_req_vld          = 2'b00;
        bus.ptw_walk_resp_vld_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_route", walker_resp_vld, (i % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            chk("drain_cnt", outstanding_cnt, 3 - i);
        end
        bus.ptw_walk_resp_vld_i = 1'b0;

        // Lock: walker1 stalled, walker0 joins, grant stays on walker1
        walker_req_vld         = 2'b10;
        addr1                  = 56'h80001000;
        bus.ptw_walk_req_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lock_vld", bus.ptw_walk_req_vld_o, 1'b1);
            chk("lock_id", bus.ptw_walk_req_id_o, 1'b1);
            chk("lock_addr", bus.ptw_walk_req_addr_o, 56'h80001000);
            chk("lock_rdy", walker_req_rdy, 2'b00);
            tick();
        end
        walker_req_vld = 2'b11;
        #1;
        chk("lock_hold_id", bus.ptw_walk_req_id_o, 1'b1);
        chk("lock_hold_addr", bus.ptw_walk_req_addr_o, 56'h80001000);
        tick();
        bus.ptw_walk_req_rdy_i = 1'b1;
        #1;
        chk("lock_acc_id", bus.ptw_walk_req_id_o, 1'b1);
        chk("lock_acc_rdy", walker_req_rdy, 2'b10);
        tick();
        chk("lock_cnt1", outstanding_cnt, 3'd1);
        walker_req_vld = 2'b01;
        #1;
        chk("after_lock_id", bus.ptw_walk_req_id_o, 1'b0);
        chk("after_lock_rdy", walker_req_rdy, 2'b01);
        tick();
        chk("lock_cnt2", outstanding_cnt, 3'd2);

        // Ordering: grants 1,0,1 answered with A,B,C
        walker_req_vld = 2'b10;
        #1;
        chk("ord_id", bus.ptw_walk_req_id_o, 1'b1);
        tick();
        chk("ord_cnt3", outstanding_cnt, 3'd3);
        walker_req_vld          = 2'b00;
        bus.ptw_walk_resp_vld_i = 1'b1;
        bus.ptw_walk_resp_pte_i = 64'hA;
        #1;
        chk("ord_a_route", walker_resp_vld, 2'b10);
        chk("ord_a_pte", walker_resp_pte, 64'hA);
        tick();
        chk("ord_cnt2", outstanding_cnt, 3'd2);

        // Backpressure on head walker 0; walker1 ready has no effect
        bus.ptw_walk_resp_pte_i = 64'hB;
        walker_resp_rdy         = 2'b10;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_rdy", bus.ptw_walk_resp_rdy_o, 1'b0);
            chk("bp_route", walker_resp_vld, 2'b01);
            tick();
            chk("bp_cnt", outstanding_cnt, 3'd2);
        end
        walker_resp_rdy = 2'b11;
        #1;
        chk("ord_b_route", walker_resp_vld, 2'b01);
        chk("ord_b_rdy", bus.ptw_walk_resp_rdy_o, 1'b1);
        chk("ord_b_pte", walker_resp_pte, 64'hB);
        tick();
        chk("ord_cnt1", outstanding_cnt, 3'd1);
        bus.ptw_walk_resp_pte_i = 64'hC;
        #1;
        chk("ord_c_route", walker_resp_vld, 2'b10);
        chk("ord_c_pte", walker_resp_pte, 64'hC);
        tick();
        chk("ord_cnt0", outstanding_cnt, 3'd0);
        chk("err_clean", protocol_err, 1'b0);

        // Response with empty FIFO sets the sticky error
        #1;
        chk("orphan_rdy", bus.ptw_walk_resp_rdy_o, 1'b0);
        chk("orphan_route", walker_resp_vld, 2'b00);
        tick();
        bus.ptw_walk_resp_vld_i = 1'b0;
        chk("err_set", protocol_err, 1'b1);
        tick();
        chk("err_sticky", protocol_err, 1'b1);

        // Reset with two outstanding
        walker_req_vld = 2'b11;
        tick();
        tick();
        chk("pre_rst_cnt", outstanding_cnt, 3'd2);
        rst                     = 1'b1;
        bus.ptw_walk_resp_vld_i = 1'b1;
        #1;
        chk("mid_rst_cnt", outstanding_cnt, 3'd0);
        chk("mid_rst_err", protocol_err, 1'b0);
        chk("mid_rst_req_vld", bus.ptw_walk_req_vld_o, 1'b0);
        chk("mid_rst_req_rdy", walker_req_rdy, 2'b00);
        chk("mid_rst_resp_vld", walker_resp_vld, 2'b00);
        chk("mid_rst_resp_rdy", bus.ptw_walk_resp_rdy_o, 1'b0);
        tick();
        rst            = 1'b0;
        walker_req_vld = 2'b00;
        #1;
        chk("post_rst_resp_rdy", bus.ptw_walk_resp_rdy_o, 1'b0);
        chk("post_rst_route", walker_resp_vld, 2'b00);
        tick();
        bus.ptw_walk_resp_vld_i = 1'b0;
        chk("post_rst_err", protocol_err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
